// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES bus constants and OAM DMA state encoding
package nes_pkg;

    localparam logic [15:0] DMA_REG_DEFAULT = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/nes_oam_dma.sv
// rtl/nes_oam_dma.sv - sprite OAM DMA engine with inline CPU/DMA bus mux
module nes_oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG = DMA_REG_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    output logic        cpu_halt,
    output logic [15:0] address,
    output logic [7:0]  out,
    output logic        rd,
    output logic        we,
    input  logic [7:0]  din,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        busy
);

    dma_state_e  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  latch_q, latch_d;
    logic        parity_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 8'h00;
            page_q   <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            page_q   <= page_d;
            latch_q  <= latch_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        page_d   = page_q;
        latch_d  = latch_q;
        oam_we   = 1'b0;
        oam_addr = count_q;
        oam_data = latch_q;

        // Bus belongs to the CPU only while idle; otherwise the DMA owns it and never writes.
        if (state_q == IDLE) begin
            address  = cpu_address;
            out      = cpu_out;
            rd       = cpu_rd;
            we       = cpu_we;
            cpu_halt = 1'b0;
            busy     = 1'b0;
        end else begin
            address  = {page_q, count_q};
            out      = 8'h00;
            rd       = 1'b0;
            we       = 1'b0;
            cpu_halt = 1'b1;
            busy     = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cpu_we && (cpu_address == DMA_REG)) begin
                    page_d  = cpu_out;
                    count_d = 8'h00;
                    state_d = HALT;
                end
            end
            HALT:  state_d = parity_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                rd      = 1'b1;
                latch_d = din;
                state_d = WRITE;
            end
            WRITE: begin
                oam_we  = 1'b1;
                count_d = count_q + 8'd1;
                state_d = (count_q != 8'hFF) ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nes_oam_dma.sv
// tb/tb_nes_oam_dma.sv - scoreboard bench for nes_oam_dma
module tb_nes_oam_dma;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_rd;
    logic        cpu_we;
    logic        cpu_halt;
    logic [15:0] address;
    logic [7:0]  out;
    logic        rd;
    logic        we;
    logic [7:0]  din;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_m [0:255];
    logic        oam_clr = 1'b0;
    int          oam_wr_total = 0;
    logic        tb_par = 1'b0;
    logic [7:0]  cur_page = 8'h00;
    logic [15:0] last_rd = 16'h0000;
    sb_t         sb [$];
    int          total = 0;
    int          bad = 0;

    nes_oam_dma dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_rd      (cpu_rd),
        .cpu_we      (cpu_we),
        .cpu_halt    (cpu_halt),
        .address     (address),
        .out         (out),
        .rd          (rd),
        .we          (we),
        .din         (din),
        .oam_addr    (oam_addr),
        .oam_data    (oam_data),
        .oam_we      (oam_we),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    assign din = mem[address];

    always @(posedge clock) tb_par <= reset ? 1'b0 : ~tb_par;

    always @(posedge clock) begin
        if (oam_clr) begin
            for (int i = 0; i < 256; i++) oam_m[i] <= 8'hEE;
        end else if (oam_we) begin
            oam_m[oam_addr] <= oam_data;
            oam_wr_total    <= oam_wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer plus bus-ownership checks while the CPU is stalled.
    always @(negedge clock) begin
        if (oam_we) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(oam_addr), 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("oam_addr", 32'(oam_addr), 32'(e.a));
                chk("oam_data", 32'(oam_data), 32'(e.d));
                chk("oam_rd", 32'(rd), 32'd0);
            end
        end
        if (cpu_halt && rd) begin
            chk("rd_page", 32'(address[15:8]), 32'(cur_page));
            last_rd = address;
        end
        if (cpu_halt && we) chk("dma_mem_we", 32'(we), 32'd0);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_dma(input logic [7:0] pg, input logic want_par,
                           input int retrig_read, input int rst_write,
                           output int halt_n);
        int n;
        int reads;
        int writes;
        int guard;
        guard = 0;
        while (tb_par != want_par && guard < 4) begin
            step();
            guard++;
        end
        for (int i = 0; i < 256; i++) sb.push_back({i[7:0], mem[{pg, i[7:0]}]});
        cur_page    = pg;
        cpu_address = 16'h4014;
        cpu_out     = pg;
        cpu_we      = 1'b1;
        cpu_rd      = 1'b0;
        #1;
        chk("trig_addr", 32'(address), 32'h4014);
        chk("trig_out", 32'(out), 32'(pg));
        chk("trig_we", 32'(we), 32'd1);
        chk("trig_halt", 32'(cpu_halt), 32'd0);
        n = 0;
        reads = 0;
        writes = 0;
        step();
        cpu_we      = 1'b0;
        cpu_out     = 8'h00;
        cpu_address = 16'h0000;
        while (cpu_halt && n < 2000) begin
            n++;
            if (rd) reads++;
            if (oam_we) writes++;
            if (rd && reads == retrig_read) begin
                cpu_address = 16'h4014;
                cpu_out     = 8'h03;
                cpu_we      = 1'b1;
                #1;
                chk("retrig_we", 32'(we), 32'd0);
                chk("retrig_out", 32'(out), 32'd0);
                chk("retrig_addr", 32'(address), 32'({pg, 8'd9}));
            end else begin
                cpu_we      = 1'b0;
                cpu_address = 16'h0000;
                cpu_out     = 8'h00;
            end
            if (oam_we && writes == rst_write) begin
                reset = 1'b1;
                step();
                chk("rst_halt", 32'(cpu_halt), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_oam_we", 32'(oam_we), 32'd0);
                reset = 1'b0;
                sb.delete();
                halt_n = n;
                return;
            end
            step();
        end
        halt_n = n;
        chk("busy_fall_writes", 32'(writes), 32'd256);
        chk("busy_after", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int miss;
        int rec;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (v == 8'hEE) v = 8'hE1;
            mem[i] = v;
        end
        reset = 1'b1;
        cpu_address = 16'h0000;
        cpu_out = 8'h00;
        cpu_rd = 1'b0;
        cpu_we = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_halt", 32'(cpu_halt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_oam_we", 32'(oam_we), 32'd0);

        cpu_address = 16'h8000;
        cpu_rd = 1'b1;
        #1;
        chk("pass_rd_addr", 32'(address), 32'h8000);
        chk("pass_rd", 32'(rd), 32'd1);
        chk("pass_rd_we", 32'(we), 32'd0);
        cpu_address = 16'h0010;
        cpu_out = 8'h55;
        cpu_rd = 1'b0;
        cpu_we = 1'b1;
        #1;
        chk("pass_wr_addr", 32'(address), 32'h0010);
        chk("pass_wr_out", 32'(out), 32'h55);
        chk("pass_wr_we", 32'(we), 32'd1);
        chk("pass_wr_rd", 32'(rd), 32'd0);
        step();
        cpu_we = 1'b0;
        cpu_out = 8'h00;
        step();

        // Trigger with parity 1 so HALT sees parity 0: even start, retrigger at READ #10.
        oam_clr = 1'b1;
        step();
        oam_clr = 1'b0;
        run_dma(8'h02, 1'b1, 10, -1, n);
        chk("even_len", 32'(n), 32'd513);
        miss = 0;
        for (int i = 0; i < 256; i++) if (oam_m[i] !== mem[16'h0200 + 16'(i)]) miss++;
        chk("even_oam", 32'(miss), 32'd0);
        step();

        oam_clr = 1'b1;
        step();
        oam_clr = 1'b0;
        run_dma(8'h02, 1'b0, -1, -1, n);
        chk("odd_len", 32'(n), 32'd514);
        miss = 0;
        for (int i = 0; i < 256; i++) if (oam_m[i] !== mem[16'h0200 + 16'(i)]) miss++;
        chk("odd_oam", 32'(miss), 32'd0);
        step();

        oam_clr = 1'b1;
        step();
        oam_clr = 1'b0;
        run_dma(8'h05, 1'b1, -1, 100, n);
        rec = oam_wr_total;
        for (int i = 0; i < 10; i++) step();
        chk("no_oam_after_rst", 32'(oam_wr_total), 32'(rec));
        chk("idle_after_rst", 32'(cpu_halt), 32'd0);
        miss = 0;
        for (int i = 0; i < 100; i++) if (oam_m[i] !== mem[16'h0500 + 16'(i)]) miss++;
        chk("rst_oam_low", 32'(miss), 32'd0);
        miss = 0;
        for (int i = 100; i < 256; i++) if (oam_m[i] !== 8'hEE) miss++;
        chk("rst_oam_high", 32'(miss), 32'd0);

        run_dma(8'hFF, 1'b1, -1, -1, n);
        chk("ff_len", 32'(n), 32'd513);
        chk("ff_last_rd", 32'(last_rd), 32'hFFFF);
        miss = 0;
        for (int i = 0; i < 256; i++) if (oam_m[i] !== mem[16'hFF00 + 16'(i)]) miss++;
        chk("ff_oam", 32'(miss), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nes_oam_dma.md
NES_OAM_DMA -- requirements
Module: nes_oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG, default 16'h4014, meaning CPU write address that starts a transfer.
REQ-002 SHALL have port clock  input  1  single system clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cpu_address  input  16  CPU bus address.
REQ-005 SHALL have port cpu_out  input  8  CPU write data.
REQ-006 SHALL have port cpu_rd  input  1  CPU read strobe.
REQ-007 SHALL have port cpu_we  input  1  CPU write strobe.
REQ-008 SHALL have port cpu_halt  output  1  stall request to CPU; CPU holds state while high.
REQ-009 SHALL have port address  output  16  memory address (muxed CPU/DMA).
REQ-010 SHALL have port out  output  8  memory write data.
REQ-011 SHALL have port rd  output  1  memory read strobe.
REQ-012 SHALL have port we  output  1  memory write strobe.
REQ-013 SHALL have port din  input  8  memory read data, valid at the posedge ending the cycle that drove the address.
REQ-014 SHALL have ports oam_addr (output, 8), oam_data (output, 8), oam_we (output, 1): sprite-memory write port.
REQ-015 SHALL have port busy  output  1  high from trigger-next cycle until the last OAM write completes.

Function
REQ-016 SHALL use states IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 SHALL, in IDLE, on cpu_we=1 and cpu_address==DMA_REG, latch page<=cpu_out, clear count to 0, go to HALT.
REQ-018 SHALL keep a parity bit toggling every clock (reset 0); HALT goes to ALIGN if parity==1 during HALT, else to READ.
REQ-019 SHALL go ALIGN -> READ unconditionally (one extra stall cycle).
REQ-020 SHALL, in READ, drive address={page,count}, rd=1, we=0, then go to WRITE, capturing din into a data latch at that posedge.
REQ-021 SHALL, in WRITE, drive oam_we=1, oam_addr=count, oam_data=latch, rd=0, we=0.
REQ-022 SHALL, on leaving WRITE, increment count (8-bit wrap) and go to READ if count!=8'hFF, else IDLE.
REQ-023 SHALL thus stall exactly 513 cycles (even alignment) or 514 (odd) after the trigger cycle.
REQ-024 SHALL assert cpu_halt and busy combinationally in all states except IDLE.
REQ-025 SHALL, in IDLE, pass cpu_address/cpu_out/cpu_rd/cpu_we straight to address/out/rd/we with zero latency.
REQ-026 SHALL, outside IDLE, drive out=0 and we=0 and ignore all CPU strobes, including further DMA_REG writes.
REQ-027 SHALL let the trigger write itself reach memory unchanged in the trigger cycle.
REQ-028 SHALL keep oam_we=0 in every state except WRITE.
REQ-029 SHALL wrap the source address within the page: {page,8'hFF} is followed by nothing; the page is never incremented.

Reset
REQ-030 SHALL, on reset=1 at posedge, force IDLE, count=0, parity=0, page=0, latch=0, regardless of state.
REQ-031 SHALL, on reset mid-transfer, drop cpu_halt, busy and oam_we the next cycle; no further OAM writes occur.

Structure
REQ-032 SHALL place the state encoding (3-bit) and DMA_REG default in shared package nes_pkg, for reuse by the PPU register decoder.
REQ-033 SHALL be one flat module with no sub-modules; the bus mux is inline.

Verification
REQ-034 Even start: write 8'h02 to 16'h4014 with parity=0 in HALT -> cpu_halt for 513 cycles; oam[i]=mem[16'h0200+i] for i=0..255.
REQ-035 Odd start: same write one cycle later -> ALIGN visited, cpu_halt for 514 cycles, same OAM contents.
REQ-036 Retrigger: write 8'h03 to 16'h4014 during READ #10 -> ignored, page stays 8'h02, we=0 on memory.
REQ-037 Reset at WRITE #100 -> next cycle IDLE, cpu_halt=0, oam_we=0; OAM 100..255 untouched.
REQ-038 Passthrough: CPU read 16'h8000 and write 8'h55 to 16'h0010 in IDLE -> address/out/rd/we mirror CPU the same cycle.
REQ-039 Page 8'hFF source -> last read at 16'hFFFF, no access to 16'h0000; busy falls after 256th oam_we.
